// File: rtl/adder_pkg.sv
// Shared op codes and flag bundle for the pipelined add/subtract unit.
package adder_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef struct packed {
        logic s;
        logic zr;
        logic cy;
        logic p;
        logic v;
    } flags_t;

endpackage

// File: rtl/adder_flags.sv
// Combinational flag derivation from a stage-1 result, its raw carry and its overflow bit.
module adder_flags
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] z,
    input  logic             cy,
    input  logic             v,
    output flags_t           flags
);

    assign flags.s  = z[WIDTH-1];
    assign flags.zr = (z == '0);
    assign flags.cy = cy;
    assign flags.p  = ~^z;
    assign flags.v  = v;

endmodule

// File: rtl/adder_pipe_flags.sv
// Two-stage add/subtract pipeline with carry chaining, result flags and a global-stall handshake.
module adder_pipe_flags
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_s,
    output logic             out_zr,
    output logic             out_cy,
    output logic             out_p,
    output logic             out_v
);

    localparam int MSB = WIDTH - 1;

    logic             adv;
    logic [WIDTH-1:0] y_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             sum_v;
    logic             creg;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_z;
    logic             s1_cy;
    logic             s1_v;
    flags_t           s1_flags;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_z;
    flags_t           s2_flags;

    // The whole pipeline moves as one: it advances whenever the output slot is free or draining.
    assign adv      = ~s2_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        y_eff = in_y;
        cin   = 1'b0;
        unique case (in_op)
            OP_ADD: cin = 1'b0;
            OP_SUB: begin
                y_eff = ~in_y;
                cin   = 1'b1;
            end
            OP_ADC: cin = creg;
            OP_SBB: begin
                y_eff = ~in_y;
                cin   = creg;
            end
            default: cin = 1'b0;
        endcase
    end

    assign sum   = {1'b0, in_x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin};
    assign sum_v = (in_x[MSB] == y_eff[MSB]) & (sum[MSB] != in_x[MSB]);

    // creg updates in stage 1, so a back-to-back ADC/SBB sees the previous beat's carry.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_z     <= '0;
            s1_cy    <= 1'b0;
            s1_v     <= 1'b0;
            creg     <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_z  <= sum[MSB:0];
                s1_cy <= sum[WIDTH];
                s1_v  <= sum_v;
                creg  <= sum[WIDTH];
            end
        end
    end

    adder_flags #(.WIDTH(WIDTH)) u_flags (
        .z     (s1_z),
        .cy    (s1_cy),
        .v     (s1_v),
        .flags (s1_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_z     <= '0;
            s2_flags <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_z     <= s1_z;
                s2_flags <= s1_flags;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_z     = s2_z;
    assign out_s     = s2_flags.s;
    assign out_zr    = s2_flags.zr;
    assign out_cy    = s2_flags.cy;
    assign out_p     = s2_flags.p;
    assign out_v     = s2_flags.v;

endmodule

// File: tb/tb_adder_pipe_flags.sv
// Self-checking bench: directed vector table, handshake corner sequences and randomized traffic.
module tb_adder_pipe_flags;
    import adder_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] z;
        logic         s;
        logic         zr;
        logic         cy;
        logic         p;
        logic         v;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;
    logic         out_s, out_zr, out_cy, out_p, out_v;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];
    bit   model_creg = 1'b0;
    bit   cur_has_exp = 1'b0;
    exp_t cur_exp;
    bit   accepted;
    bit   prev_stall = 1'b0;
    exp_t prev_out;
    vec_t tbl[9];

    adder_pipe_flags #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_s     (out_s),
        .out_zr    (out_zr),
        .out_cy    (out_cy),
        .out_p     (out_p),
        .out_v     (out_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic [W-1:0] z, input logic s, zr, cy, p, v);
        exp_t e;
        e.z = z; e.s = s; e.zr = zr; e.cy = cy; e.p = p; e.v = v;
        return e;
    endfunction

    // Reference: unsigned result and carry from plain integer arithmetic, overflow from the
    // true signed result leaving the representable range.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint c  = model_creg ? 1 : 0;
        longint m  = 64'sd1 << W;
        longint ur, sr;
        exp_t   e;
        case (op)
            OP_ADD:  begin ur = ux + uy;             sr = sx + sy;         end
            OP_SUB:  begin ur = ux - uy + m;         sr = sx - sy;         end
            OP_ADC:  begin ur = ux + uy + c;         sr = sx + sy + c;     end
            default: begin ur = ux - uy - 1 + c + m; sr = sx - sy - 1 + c; end
        endcase
        e.z  = ur[W-1:0];
        e.cy = (ur >= m);
        e.s  = e.z[W-1];
        e.zr = (e.z == 0);
        e.p  = ($countones(e.z) % 2) == 0;
        e.v  = (sr > (m / 2 - 1)) || (sr < -(m / 2));
        model_creg = e.cy;
        return e;
    endfunction

    function automatic exp_t dut_out();
        return {out_z, out_s, out_zr, out_cy, out_p, out_v};
    endfunction

    // One clock: sample handshakes on the falling edge, then return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (prev_stall) check("hold_stable", {out_valid, dut_out()}, {1'b1, prev_out});
        if (out_valid && out_ready) begin
            check("beat_expected", q.size() != 0, 1);
            if (q.size() != 0) check("result", dut_out(), q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = dut_out();
        if (in_valid && in_ready) begin
            e = model(in_op, in_x, in_y);
            if (cur_has_exp) e = cur_exp;
            q.push_back(e);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit has_exp, input exp_t e);
        in_op = op; in_x = x; in_y = y; in_valid = 1'b1;
        cur_has_exp = has_exp; cur_exp = e;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) cycle();
        check("accept_timeout", accepted, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) cycle();
        check("drain_empty", q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 16'h8000;
            3: return 16'h7fff;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        tbl[0] = '{OP_ADD, 16'h8fff, 16'h8000, mk(16'h0fff, 0, 0, 1, 1, 1)};
        tbl[1] = '{OP_ADD, 16'hfffe, 16'h0002, mk(16'h0000, 0, 1, 1, 1, 0)};
        tbl[2] = '{OP_ADD, 16'haaaa, 16'h5555, mk(16'hffff, 1, 0, 0, 1, 0)};
        tbl[3] = '{OP_SUB, 16'h0005, 16'h0007, mk(16'hfffe, 1, 0, 0, 0, 0)};
        tbl[4] = '{OP_SUB, 16'h8000, 16'h0001, mk(16'h7fff, 0, 0, 1, 0, 1)};
        tbl[5] = '{OP_ADD, 16'hffff, 16'h0001, mk(16'h0000, 0, 1, 1, 1, 0)};
        tbl[6] = '{OP_ADC, 16'h0000, 16'h0000, mk(16'h0001, 0, 0, 0, 0, 0)};
        tbl[7] = '{OP_SUB, 16'h0000, 16'h0001, mk(16'hffff, 1, 0, 0, 1, 0)};
        tbl[8] = '{OP_SBB, 16'h0000, 16'h0000, mk(16'hffff, 1, 0, 0, 1, 0)};

        rst_n = 1'b0; in_valid = 1'b0; in_op = OP_ADD; in_x = '0; in_y = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {out_valid, dut_out()}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);

        // Two-cycle latency from accept with no stall.
        send(OP_ADD, 16'h8fff, 16'h8000, 1'b1, tbl[0].e);
        in_valid = 1'b0;
        check("latency_1cyc_no_valid", out_valid, 0);
        cycle();
        check("latency_2cyc_valid", out_valid, 1);
        drain();

        // Directed vectors back-to-back, including the carry chains.
        for (int i = 0; i < 9; i++) send(tbl[i].op, tbl[i].x, tbl[i].y, 1'b1, tbl[i].e);
        drain();

        // Backpressure: A and B accepted, C held off while A's result is stalled at the output.
        out_ready = 1'b0;
        send(OP_ADD, 16'h1234, 16'h1111, 1'b0, '0);
        send(OP_SUB, 16'h0100, 16'h0200, 1'b0, '0);
        in_op = OP_ADC; in_x = 16'h7fff; in_y = 16'h0001; cur_has_exp = 1'b0;
        check("bp_in_ready_low", in_ready, 0);
        repeat (3) begin
            cycle();
            check("bp_hold_a", out_z, q[0].z);
        end
        out_ready = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 10 && !accepted; k++) cycle();
        check("bp_c_accepted", accepted, 1);
        drain();

        // Reset with two beats in flight and creg set.
        out_ready = 1'b0;
        send(OP_ADD, 16'hffff, 16'h0001, 1'b0, '0);
        send(OP_ADC, 16'hffff, 16'h0000, 1'b0, '0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {out_valid, dut_out()}, 0);
        q.delete();
        model_creg = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(OP_ADC, 16'h0001, 16'h0001, 1'b1, mk(16'h0002, 0, 0, 0, 0, 0));
        drain();

        // Randomized traffic with random stalls on both sides.
        cur_has_exp = 1'b0;
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom);
            in_x      = pick();
            in_y      = pick();
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
